// File: rtl/sub_serial_16bit_if.sv
// Start/busy/done handshake and operand/result bundle for sub_serial_16bit.
// The master drives operands and start; the slave returns result and flags.
interface sub_serial_16bit_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        inicio;
    logic        ocupado;
    logic        pronto;
    logic [15:0] resultado;
    logic        borrow_out;
    logic        zero;
    logic        overflow;

    modport master (
        output a, b, borrow_in, inicio,
        input  ocupado, pronto, resultado, borrow_out, zero, overflow
    );

    modport slave (
        input  a, b, borrow_in, inicio,
        output ocupado, pronto, resultado, borrow_out, zero, overflow
    );
endinterface

// File: rtl/sub_serial_16bit.sv
// Multi-cycle 16-bit subtractor, LARGURA_PASSO bits per cycle, registered borrow.
// Define SUB_SERIAL_FLAGS_EN to build the ZERO/OVERFLOW flag registers.
module sub_serial_16bit #(
    parameter int LARGURA_PASSO = 4
) (
    input logic               clk,
    input logic               rst_n,
    sub_serial_16bit_if.slave bus
);
    localparam int W  = LARGURA_PASSO;
    localparam int N  = 16 / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   a_q;
    logic [15:0]   b_q;
    logic [15:0]   acc_q;
    logic          brw_q;
    logic [15:0]   res_q;
    logic          bo_q;

    logic [W:0]    diff;
    logic [15:0]   acc_nxt;
    logic          last;
    logic          accept;

    assign diff = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]}
                - {{W{1'b0}}, brw_q};

    // Slices enter at the top and drift down, so the LSB slice ends at bit 0.
    assign acc_nxt = (acc_q >> W) | (16'(diff[W-1:0]) << (16 - W));

    assign last   = (state_q == CALCULA) && (cnt_q == CW'(N - 1));
    assign accept = (state_q != CALCULA) && bus.inicio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCIOSO;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            bo_q    <= 1'b0;
        end else begin
            unique case (state_q)
                CALCULA: begin
                    a_q     <= a_q >> W;
                    b_q     <= b_q >> W;
                    brw_q   <= diff[W];
                    acc_q   <= acc_nxt;
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= last ? FIM : CALCULA;
                end
                default: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        brw_q   <= bus.borrow_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALCULA;
                    end else begin
                        state_q <= OCIOSO;
                    end
                end
            endcase
            if (last) begin
                res_q <= acc_nxt;
                bo_q  <= diff[W];
            end
        end
    end

`ifdef SUB_SERIAL_FLAGS_EN
    logic sa_q;
    logic sb_q;
    logic zero_q;
    logic ovf_q;

    // Operand sign bits are kept aside because the working registers shift out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                sa_q <= bus.a[15];
                sb_q <= bus.b[15];
            end
            if (last) begin
                zero_q <= (acc_nxt == 16'h0000);
                ovf_q  <= (sa_q != sb_q) && (acc_nxt[15] != sa_q);
            end
        end
    end

    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
`else
    assign bus.zero     = 1'b0;
    assign bus.overflow = 1'b0;
`endif

    assign bus.ocupado    = (state_q == CALCULA);
    assign bus.pronto     = (state_q == FIM);
    assign bus.resultado  = res_q;
    assign bus.borrow_out = bo_q;
endmodule

// File: doc/sub_serial_16bit.md
# sub_serial_16bit

Multi-cycle 16-bit subtractor that computes RESULTADO = A − B − BORROW_IN over several clock cycles, processing LARGURA_PASSO bits per cycle with a registered borrow chain. It is the subtraction counterpart of the combinational 16-bit ripple adder in the ALU datapath. It trades latency for a short critical path, and a start/busy/done handshake lets the ALU controller sequence it.

## Interface
- LARGURA_PASSO, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16. Number of steps N = 16/LARGURA_PASSO.
- CLK  input  1  clock, all state updates on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- A  input  16  minuend, sampled only on the accept edge
- B  input  16  subtrahend, sampled only on the accept edge
- BORROW_IN  input  1  borrow into bit 0, sampled only on the accept edge
- INICIO  input  1  start request
- OCUPADO  output  1  high while an operation is in progress
- PRONTO  output  1  one-cycle pulse when RESULTADO/flags are updated
- RESULTADO  output  16  final difference (mod 2^16)
- BORROW_OUT  output  1  1 when A < B + BORROW_IN (unsigned)
- ZERO  output  1  RESULTADO == 0 (see Configuration)
- OVERFLOW  output  1  signed overflow (see Configuration)

## Operation
- FSM states: OCIOSO (idle), CALCULA (stepping), FIM (completion).
- OCIOSO: OCUPADO=0. INICIO=1 at an edge is accepted. On acceptance, latch A, B, BORROW_IN into working registers, clear the step counter, and go to CALCULA.
- CALCULA: OCUPADO=1. Each edge subtracts the next LARGURA_PASSO-bit slice, LSB slice first, using the registered borrow. The slice result goes into the working register and the step counter increments. After step N the FSM goes to FIM.
- FIM: lasts one cycle. PRONTO=1 and OCUPADO=0 during this cycle. INICIO=1 in this cycle is accepted exactly as in OCIOSO and moves the FSM to CALCULA. Otherwise the FSM returns to OCIOSO.
- Result update: RESULTADO, BORROW_OUT, ZERO and OVERFLOW update only on the edge that enters FIM. They hold their last final value at all other times and never expose partial slices.
- Arithmetic: RESULTADO = (A − B − BORROW_IN) mod 2^16. BORROW_OUT is the borrow out of bit 15.
- OVERFLOW = (A[15] ≠ B[15]) and (RESULTADO[15] ≠ A[15]).
- INICIO while in CALCULA is ignored and is not queued.
- Input changes on A, B or BORROW_IN after the accept edge have no effect on the operation in progress.

## Timing
- Reset (RESET_N=0, asynchronous):
  - FSM returns to OCIOSO and the counter and working registers clear.
  - OCUPADO=0, PRONTO=0, RESULTADO=0x0000, BORROW_OUT=0, ZERO=0, OVERFLOW=0.
- Reset asserted mid-operation aborts the operation. No PRONTO pulse is produced and outputs take their reset values immediately.
- Release of RESET_N is synchronous to CLK. INICIO is honoured from the first rising edge after release.
- Latency: accept at edge t0. OCUPADO=1 from t0 until edge tN. PRONTO=1 for the cycle between tN and tN+1.
  - Default LARGURA_PASSO=4 gives N=4. LARGURA_PASSO=16 gives N=1.
- Back-to-back throughput is one operation per N+1 cycles, with INICIO held high during FIM.

## Configuration
- SUB_SERIAL_FLAGS_EN defined: ZERO and OVERFLOW are computed and registered as described above.
- SUB_SERIAL_FLAGS_EN undefined: ZERO and OVERFLOW are tied to 0 and their registers and logic are removed. RESULTADO, BORROW_OUT and the handshake are unchanged.

## Test plan
- A=0x1234, B=0x0034, BORROW_IN=0, pulse INICIO → OCUPADO high 4 cycles, then PRONTO pulse with RESULTADO=0x1200, BORROW_OUT=0, ZERO=0, OVERFLOW=0.
- A=0x0000, B=0x0001, BORROW_IN=0 → RESULTADO=0xFFFF, BORROW_OUT=1. A=0x0010, B=0x000F, BORROW_IN=1 → RESULTADO=0x0000, ZERO=1, BORROW_OUT=0.
- A=0x8000, B=0x0001 → RESULTADO=0x7FFF, OVERFLOW=1, BORROW_OUT=0. With SUB_SERIAL_FLAGS_EN undefined: same RESULTADO, OVERFLOW=0.
- Start 0x5555−0x1111, then pulse INICIO with A=0xFFFF and B=0xFFFF during CALCULA → second request ignored. Exactly one PRONTO, with RESULTADO=0x4444.
- Hold INICIO high continuously with operands changing each op → accepts every N+1 cycles. Each PRONTO reflects the operands present on its accept edge.
- Assert RESET_N=0 during step 2 → outputs zero immediately and no PRONTO. After release, a new operation completes with correct latency.
- Run scenario 1 with LARGURA_PASSO=1 and with LARGURA_PASSO=16 → identical results, with latency 16 and 1 respectively.
